// File: rtl/sub_pkg.sv
// Shared helpers for the pipelined add/subtract unit: slice sizing and
// 4-bit group propagate/generate equations.
package sub_pkg;

    localparam int MIN_SW = 4;

    function automatic int sw_f(input int width, input int stages);
        return width / stages;
    endfunction

    // Returns {group_propagate, group_generate} for one 4-bit group.
    // Propagate is the OR form (a | b'), so generate implies propagate.
    function automatic logic [1:0] cla4_f(input logic [3:0] g, input logic [3:0] p);
        logic pp;
        logic gg;
        pp = &p;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {pp, gg};
    endfunction

endpackage

// File: rtl/sub_cla_slice.sv
// Combinational SW-bit carry-lookahead adder slice: 4-bit P/G groups with a
// group-level lookahead feeding each group's carry-in.
module sub_cla_slice
    import sub_pkg::*;
#(
    parameter int SW = 16
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          pg,
    output logic          gg
);

    localparam int NG = (SW + 3) / 4;
    localparam int PW = NG * 4;

    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [PW-1:0] x;
    logic [PW:0]   c;
    logic [NG-1:0] grp_p;
    logic [NG-1:0] grp_g;
    logic [NG:0]   cg;

    always_comb begin
        // Pad bits propagate and never generate, so a partial top group is transparent.
        g = '0;
        p = '1;
        x = '0;
        g[SW-1:0] = a & b;
        p[SW-1:0] = a | b;
        x[SW-1:0] = a ^ b;

        cg[0] = cin;
        gg    = 1'b0;
        for (int j = 0; j < NG; j++) begin
            {grp_p[j], grp_g[j]} = cla4_f(g[4*j +: 4], p[4*j +: 4]);
            cg[j+1] = grp_g[j] | (grp_p[j] & cg[j]);
            gg      = grp_g[j] | (grp_p[j] & gg);
        end
        pg = &grp_p;

        c = '0;
        for (int j = 0; j < NG; j++) begin
            c[4*j] = cg[j];
            for (int t = 1; t < 4; t++) begin
                c[4*j+t] = g[4*j+t-1] | (p[4*j+t-1] & c[4*j+t-1]);
            end
        end
        c[PW] = cg[NG];

        cout = c[SW];
        sum  = x[SW-1:0] ^ c[SW-1:0];
    end

endmodule

// File: rtl/sub_pipe_nbit.sv
// Pipelined WIDTH-bit add/subtract: one SW-bit slice resolved per stage, carry
// registered between stages, elastic valid/ready flow with collapsing bubbles.
module sub_pipe_nbit
    import sub_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             bout,
    output logic             ovf
);

    localparam int SW = sw_f(WIDTH, STAGES);

    if ((WIDTH % STAGES) != 0 || (WIDTH / STAGES) < MIN_SW) begin : g_bad_params
        $error("sub_pipe_nbit: WIDTH must split into STAGES slices of at least %0d bits", MIN_SW);
    end

    // b holds the mode-adjusted operand (inverted for subtract); borrow is in carry form.
    typedef struct packed {
        logic             op_sub;
        logic             borrow;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
    } stage_t;

    stage_t            st_q [STAGES];
    stage_t            st_d [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES:0]   vchain;
    logic [STAGES-1:0] load;
    logic [STAGES:0]   adv;

    assign vchain      = {v_q, in_valid};
    assign adv[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t          src;
        stage_t          nxt;
        logic [SW-1:0]   sum;
        logic            cout;
        logic            pg_unused;
        logic            gg_unused;

        assign load[k] = ~v_q[k] | adv[k+1];
        assign adv[k]  = load[k];

        if (k == 0) begin : g_src_in
            always_comb begin
                src.op_sub = op_sub;
                src.borrow = op_sub;
                src.a      = din1;
                src.b      = op_sub ? ~din2 : din2;
                src.res    = '0;
            end
        end else begin : g_src_pipe
            assign src = st_q[k-1];
        end

        sub_cla_slice #(.SW(SW)) u_slice (
            .a   (src.a[k*SW +: SW]),
            .b   (src.b[k*SW +: SW]),
            .cin (src.borrow),
            .sum (sum),
            .cout(cout),
            .pg  (pg_unused),
            .gg  (gg_unused)
        );

        always_comb begin
            nxt                 = src;
            nxt.res[k*SW +: SW] = sum;
            nxt.borrow          = cout;
        end

        assign st_d[k] = nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v_q[k] <= vchain[k];
                end
                if (load[k] && vchain[k]) begin
                    st_q[k] <= st_d[k];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[STAGES-1];
    assign dout      = st_q[STAGES-1].res;
    assign bout      = st_q[STAGES-1].op_sub ^ st_q[STAGES-1].borrow;
    assign ovf       = (st_q[STAGES-1].a[WIDTH-1] == st_q[STAGES-1].b[WIDTH-1]) &&
                       (st_q[STAGES-1].res[WIDTH-1] != st_q[STAGES-1].a[WIDTH-1]);

endmodule
